program_loader: RTL

- Boot-time writer for the instruction memory that the core fetches from.
- Accepts a byte stream over a valid/ready handshake, typically from a UART receiver.
- Packs each group of 4 bytes into one 28-bit instruction word and writes it to sequential addresses from 0.
- Holds the core in reset until the image has been written, then releases it.

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_word_assembler.sv | 47 ++++
 rtl/program_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encodings and constants for the program loader
package program_loader_pkg;

  typedef enum logic [2:0] {
    LDR_CNT_HI,
    LDR_CNT_LO,
    LDR_DATA,
    LDR_WRITE,
    LDR_CHK,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_t;

  localparam int LDR_BYTES_PER_WORD = 4;
  localparam int LDR_INSTR_W = 28;
  localparam logic [1:0] LDR_LAST_BYTE = 2'(LDR_BYTES_PER_WORD - 1);

endpackage

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - big-endian byte-to-instruction shift register with byte index
module ldr_word_assembler
  import program_loader_pkg::*;
#(
  parameter int INSTR_W = LDR_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_done
);

  // The register is only INSTR_W wide: after four shifts the top nibble of
  // the first byte has already fallen off, which is exactly the ignored field.
  logic [INSTR_W-1:0] word_q, word_d;
  logic [1:0]         idx_q, idx_d;

  // Next-state for the shift register and byte index.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (shift_en) begin
      word_d = {word_q[INSTR_W-9:0], byte_in};
      idx_d  = idx_q + 2'd1;
    end
  end

  // Assembly state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word      = word_q;
  assign word_done = shift_en && !clear && (idx_q == LDR_LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot image loader; PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum byte
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = LDR_INSTR_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iRestart,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  output logic               oByteReady,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [INSTR_W-1:0] oWriteData,
  output logic               oCoreReset,
  output logic               oDone,
  output logic               oError
);

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam ldr_state_t AFTER_LAST = LDR_CHK;
`else
  localparam ldr_state_t AFTER_LAST = LDR_DONE;
`endif

  ldr_state_t         state_q, state_d;
  logic [7:0]         cnt_hi_q, cnt_hi_d;
  logic [15:0]        rem_q, rem_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               core_rst_q, core_rst_d;
  logic               xfer, asm_clear, asm_shift, asm_done;
  logic [15:0]        count_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         chk_total;
  assign chk_total = sum_q + iByte;
`endif

  assign xfer    = iByteValid && ready_q;
  assign count_n = {cnt_hi_q, iByte};

  ldr_word_assembler #(.INSTR_W(INSTR_W)) u_asm (
    .clk      (Clock),
    .rst      (Reset),
    .clear    (asm_clear),
    .shift_en (asm_shift),
    .byte_in  (iByte),
    .word     (oWriteData),
    .word_done(asm_done)
  );

  // Next-state, counters and registered output decode from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_hi_d  = cnt_hi_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    asm_clear = 1'b0;
    asm_shift = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      LDR_CNT_HI: if (xfer) begin
        cnt_hi_d = iByte;
        state_d  = LDR_CNT_LO;
      end
      LDR_CNT_LO: if (xfer) begin
        rem_d     = count_n;
        addr_d    = '0;
        asm_clear = 1'b1;
        if (count_n == 16'd0)            state_d = AFTER_LAST;
        else if ({1'b0, count_n} > DEPTH) state_d = LDR_ERROR;
        else                             state_d = LDR_DATA;
      end
      LDR_DATA: if (xfer) begin
        asm_shift = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q + iByte;
`endif
        if (asm_done) state_d = LDR_WRITE;
      end
      LDR_WRITE: begin
        rem_d = rem_q - 16'd1;
        // Hold the address on the last word so N == DEPTH never wraps to 0.
        if (rem_q == 16'd1) begin
          state_d = AFTER_LAST;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = LDR_DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      LDR_CHK: if (xfer) begin
        state_d = (chk_total == 8'd0) ? LDR_DONE : LDR_ERROR;
      end
`endif
      LDR_DONE, LDR_ERROR: if (iRestart) begin
        state_d  = LDR_CNT_HI;
        cnt_hi_d = '0;
        rem_d    = '0;
        addr_d   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d    = '0;
`endif
      end
      default: state_d = LDR_ERROR;
    endcase

    ready_d    = state_d inside {LDR_CNT_HI, LDR_CNT_LO, LDR_DATA, LDR_CHK};
    we_d       = (state_d == LDR_WRITE);
    done_d     = (state_d == LDR_DONE);
    err_d      = (state_d == LDR_ERROR);
    core_rst_d = (state_d != LDR_DONE);
  end

  // State, counter and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= LDR_CNT_HI;
      cnt_hi_q   <= '0;
      rem_q      <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      rem_q      <= rem_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign oByteReady    = ready_q;
  assign oWriteEnable  = we_q;
  assign oWriteAddress = addr_q;
  assign oCoreReset    = core_rst_q;
  assign oDone         = done_q;
  assign oError        = err_q;

endmodule
